// File: rtl/RSA_pkg.sv
// RSA_pkg
// Shared definitions for the RSA datapath blocks.
//   MOD_WIDTH : width of msg, key, modulus and every value derived from them
//   KeyType   : one MOD_WIDTH-bit operand
//   pre_state_t : states of the base precompute FSM, visible to benches
package RSA_pkg;

   localparam int MOD_WIDTH = 256;

   typedef logic [MOD_WIDTH-1:0] KeyType;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pre_state_t;

endpackage

// File: rtl/rsa_mod_double.sv
// rsa_mod_double
// Combinational modular doubling: o_r = (2*i_r) mod i_n.
// Requires i_r < i_n, so a single conditional subtraction is enough.
// Ports:
//   i_r : current residue, KeyType
//   i_n : modulus, KeyType
//   o_r : (2*i_r) mod i_n, KeyType
module rsa_mod_double
   import RSA_pkg::*;
(
   input  KeyType i_r,
   input  KeyType i_n,
   output KeyType o_r
);

   // One extra bit so 2*r never overflows before the compare.
   logic [MOD_WIDTH:0] w_d;
   logic [MOD_WIDTH:0] w_n_ext;
   logic [MOD_WIDTH:0] w_diff;
   logic               w_ge;

   assign w_d     = {i_r, 1'b0};
   assign w_n_ext = {1'b0, i_n};
   assign w_diff  = w_d - w_n_ext;
   assign w_ge    = (w_d >= w_n_ext);

   // The result is < N, so dropping the top bit loses nothing.
   assign o_r = w_ge ? w_diff[MOD_WIDTH-1:0] : w_d[MOD_WIDTH-1:0];

endmodule

// File: rtl/rsa_pre_base.sv
// rsa_pre_base
// Precompute stage in front of the Montgomery exponentiator. It accepts one
// job (msg, key, modulus N) and computes 2^POWER mod N by POWER modular
// doublings, one per clock. It then presents the base alongside the
// unchanged job fields.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_valid / i_ready   : job handshake (i_ready high only in IDLE)
//   i_msg, i_key        : passed through unchanged
//   i_modulus           : N, odd and >= 1
//   o_valid / o_ready   : result handshake
//   o_base              : 2^POWER mod N
//   o_msg, o_key, o_modulus : registered copies of the accepted job
module rsa_pre_base
   import RSA_pkg::*;
#(
   parameter int POWER = 2 * MOD_WIDTH
)
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_valid,
   output logic   i_ready,
   input  KeyType i_msg,
   input  KeyType i_key,
   input  KeyType i_modulus,
   output logic   o_valid,
   input  logic   o_ready,
   output KeyType o_base,
   output KeyType o_msg,
   output KeyType o_key,
   output KeyType o_modulus
);

   // Sized to hold POWER itself so the final increment never wraps.
   localparam int CNT_W = $clog2(POWER + 1);

   pre_state_t       r_state;
   pre_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   KeyType           r_base;
   KeyType           r_msg;
   KeyType           r_key;
   KeyType           r_mod;
   KeyType           w_dbl;
   logic             w_accept;
   logic             w_last;

   assign w_accept = (r_state == IDLE) && i_valid;
   assign w_last   = (r_cnt == CNT_W'(POWER - 1));

   rsa_mod_double u_dbl (
      .i_r (r_base),
      .i_n (r_mod),
      .o_r (w_dbl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_valid) w_state_nxt = RUN;
         RUN:     if (w_last)  w_state_nxt = DONE;
         DONE:    if (o_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_base <= '0;
         r_msg  <= '0;
         r_key  <= '0;
         r_mod  <= '0;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_msg  <= i_msg;
         r_key  <= i_key;
         r_mod  <= i_modulus;
         // 2^0 mod 1 is 0; starting at 0 keeps the invariant r < N.
         r_base <= (i_modulus == KeyType'(1)) ? KeyType'(0) : KeyType'(1);
      end else if (r_state == RUN) begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_base <= w_dbl;
      end
   end

   // Handshake flags depend on the state register only.
   assign i_ready   = (r_state == IDLE);
   assign o_valid   = (r_state == DONE);
   assign o_base    = r_base;
   assign o_msg     = r_msg;
   assign o_key     = r_key;
   assign o_modulus = r_mod;

endmodule
